// File: rtl/out_layer.sv
// out_layer: output-layer stage of the MLP coprocessor.
// For each of the 64 rows held in hRES_RAM (two interleaved hidden
// activations per row) it forms bias*256 + h1*w1 + h2*w2 (unsigned),
// maps that sum through the sigmoid LUT in sigm_RAM and writes one result
// per row into RES_RAM. The weights are read once per pass from wout_RAM.
//
// Ports:
//   clk, reset           single rising-edge clock, synchronous active-high reset
//   Start                begins one 64-row pass (honoured only in IDLE)
//   Done                 one-cycle pulse after the last RES write
//   hRES_read_*          hidden-result RAM read port (1-cycle latency)
//   wout_read_*          weight RAM read port: 0 = bias, 1 = w1, 2 = w2
//   sigm_read_*          sigmoid LUT read port
//   RES_write_*          result RAM write port, one write per row
//
// Build option OUT_LAYER_SATURATE_EN: when defined, the LUT index is the
// sum shifted right by 8 and clamped to the top entry; otherwise the
// shifted sum is truncated to the index width.
module out_layer #(
  parameter int width           = 8,
  parameter int hRES_depth_bits = 7,
  parameter int wout_depth_bits = 2,
  parameter int sigm_depth_bits = 8,
  parameter int RES_depth_bits  = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       Start,
  output logic                       Done,
  output logic                       hRES_read_en,
  output logic [hRES_depth_bits-1:0] hRES_read_address,
  input  logic [width-1:0]           hRES_read_data_out,
  output logic                       wout_read_en,
  output logic [wout_depth_bits-1:0] wout_read_address,
  input  logic [width-1:0]           wout_read_data_out,
  output logic                       sigm_read_en,
  output logic [sigm_depth_bits-1:0] sigm_read_address,
  input  logic [width-1:0]           sigm_read_data_out,
  output logic                       RES_write_en,
  output logic [RES_depth_bits-1:0]  RES_write_address,
  output logic [width-1:0]           RES_write_data_in
);

  localparam int ACC_W = 2 * width + 2;

  typedef enum logic [3:0] {
    IDLE, LOAD_W, READ_H1, READ_H2, CAP_H2, ACCUM, SIG_LOOKUP, WRITE, FINISH
  } state_t;

  state_t state, state_next;

  logic [1:0]                 wcnt;
  logic [RES_depth_bits-1:0]  row;
  logic [width-1:0]           bias, w1, w2, h1, h2;
  logic [sigm_depth_bits-1:0] lut_idx;
  logic [ACC_W-1:0]           acc;
  logic [ACC_W-1:0]           acc_shr;
  logic [sigm_depth_bits-1:0] lut_idx_next;

  // Only the LUT index derived from the sum is kept; the full sum is
  // combinational in ACCUM and never needed afterwards.
  always_comb begin
    acc = ACC_W'({bias, {width{1'b0}}})
        + ACC_W'(h1) * ACC_W'(w1)
        + ACC_W'(h2) * ACC_W'(w2);
    acc_shr = acc >> width;
`ifdef OUT_LAYER_SATURATE_EN
    lut_idx_next = (acc_shr > ACC_W'({sigm_depth_bits{1'b1}})) ? '1
                                                               : sigm_depth_bits'(acc_shr);
`else
    lut_idx_next = sigm_depth_bits'(acc_shr);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt    <= '0;
      row     <= '0;
      bias    <= '0;
      w1      <= '0;
      w2      <= '0;
      h1      <= '0;
      h2      <= '0;
      lut_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            wcnt <= '0;
            row  <= '0;
          end
        end
        LOAD_W: begin
          // Data for address k arrives while address k+1 is presented.
          wcnt <= wcnt + 2'd1;
          case (wcnt)
            2'd1:    bias <= wout_read_data_out;
            2'd2:    w1   <= wout_read_data_out;
            2'd3:    w2   <= wout_read_data_out;
            default: ;
          endcase
        end
        READ_H2: h1 <= hRES_read_data_out;
        CAP_H2:  h2 <= hRES_read_data_out;
        ACCUM:   lut_idx <= lut_idx_next;
        WRITE: begin
          if (row != '1) row <= row + RES_depth_bits'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next        = state;
    Done              = 1'b0;
    hRES_read_en      = 1'b0;
    hRES_read_address = '0;
    wout_read_en      = 1'b0;
    wout_read_address = '0;
    sigm_read_en      = 1'b0;
    sigm_read_address = '0;
    RES_write_en      = 1'b0;
    RES_write_address = '0;
    RES_write_data_in = '0;
    case (state)
      IDLE: begin
        if (Start) state_next = LOAD_W;
      end
      LOAD_W: begin
        if (wcnt != 2'd3) begin
          wout_read_en      = 1'b1;
          wout_read_address = wout_depth_bits'(wcnt);
        end else begin
          state_next = READ_H1;
        end
      end
      READ_H1: begin
        hRES_read_en      = 1'b1;
        hRES_read_address = hRES_depth_bits'({row, 1'b0});
        state_next        = READ_H2;
      end
      READ_H2: begin
        hRES_read_en      = 1'b1;
        hRES_read_address = hRES_depth_bits'({row, 1'b1});
        state_next        = CAP_H2;
      end
      CAP_H2: state_next = ACCUM;
      ACCUM:  state_next = SIG_LOOKUP;
      SIG_LOOKUP: begin
        sigm_read_en      = 1'b1;
        sigm_read_address = lut_idx;
        state_next        = WRITE;
      end
      WRITE: begin
        RES_write_en      = 1'b1;
        RES_write_address = row;
        RES_write_data_in = sigm_read_data_out;
        state_next        = (row == '1) ? FINISH : READ_H1;
      end
      FINISH: begin
        Done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_out_layer.sv
// Testbench for out_layer: behavioural RAM models around the DUT, directed
// weight/activation patterns with hand-derived expected results.
module tb_out_layer;

  logic       clk = 1'b0;
  logic       reset;
  logic       Start;
  logic       Done;
  logic       hRES_read_en;
  logic [6:0] hRES_read_address;
  logic [7:0] hRES_read_data_out = '0;
  logic       wout_read_en;
  logic [1:0] wout_read_address;
  logic [7:0] wout_read_data_out = '0;
  logic       sigm_read_en;
  logic [7:0] sigm_read_address;
  logic [7:0] sigm_read_data_out = '0;
  logic       RES_write_en;
  logic [5:0] RES_write_address;
  logic [7:0] RES_write_data_in;

  always #5 clk = ~clk;

  out_layer #(
    .width(8),
    .hRES_depth_bits(7),
    .wout_depth_bits(2),
    .sigm_depth_bits(8),
    .RES_depth_bits(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Start(Start),
    .Done(Done),
    .hRES_read_en(hRES_read_en),
    .hRES_read_address(hRES_read_address),
    .hRES_read_data_out(hRES_read_data_out),
    .wout_read_en(wout_read_en),
    .wout_read_address(wout_read_address),
    .wout_read_data_out(wout_read_data_out),
    .sigm_read_en(sigm_read_en),
    .sigm_read_address(sigm_read_address),
    .sigm_read_data_out(sigm_read_data_out),
    .RES_write_en(RES_write_en),
    .RES_write_address(RES_write_address),
    .RES_write_data_in(RES_write_data_in)
  );

  logic [7:0] hmem [128];
  logic [7:0] wmem [4];
  logic [7:0] smem [256];
  logic [7:0] res_mem [64];

  int total = 0;
  int bad   = 0;

  int wr_total   = 0;
  int order_bad  = 0;
  int done_total = 0;
  int overlap    = 0;
  logic [5:0] exp_addr = '0;

  // RAM models plus write bookkeeping
  always @(posedge clk) begin
    if (hRES_read_en) hRES_read_data_out <= hmem[hRES_read_address];
    if (wout_read_en) wout_read_data_out <= wmem[wout_read_address];
    if (sigm_read_en) sigm_read_data_out <= smem[sigm_read_address];
    if (RES_write_en) begin
      res_mem[RES_write_address] <= RES_write_data_in;
      if (RES_write_address !== exp_addr) order_bad++;
      exp_addr = RES_write_address + 6'd1;
      wr_total++;
    end
    if (reset) exp_addr = '0;
  end

  always @(negedge clk) begin
    if (Done === 1'b1) done_total++;
    if (int'(hRES_read_en) + int'(wout_read_en) + int'(sigm_read_en) + int'(RES_write_en) > 1)
      overlap++;
  end

  task automatic load_unit();
    for (int i = 0; i < 128; i++) hmem[i] = 8'd128;
    wmem[0] = 8'd0; wmem[1] = 8'd1; wmem[2] = 8'd1; wmem[3] = 8'd0;
  endtask

  task automatic load_ramp();
    for (int r = 0; r < 64; r++) begin
      hmem[2*r]   = 8'(4 * r);
      hmem[2*r+1] = 8'(4 * r);
    end
    wmem[0] = 8'd10; wmem[1] = 8'd2; wmem[2] = 8'd3; wmem[3] = 8'd0;
  endtask

  // Starts a pass and returns the length in cycles, counting the Start
  // cycle and the Done cycle; -1 if Done never appears.
  task automatic run_pass(output int span, output logic first_en, output logic [1:0] first_addr);
    bit found;
    found = 0;
    first_en = 1'b0;
    first_addr = '0;
    @(negedge clk);
    Start = 1'b1;
    span = 1;
    @(posedge clk);
    #1 Start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      span++;
      if (span == 2) begin
        first_en = wout_read_en;
        first_addr = wout_read_address;
      end
      if (Done === 1'b1) begin
        found = 1;
        break;
      end
    end
    if (!found) span = -1;
  endtask

  task automatic test_reset();
    logic [35:0] ov;
    reset = 1'b1;
    Start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ov = {Done, hRES_read_en, wout_read_en, sigm_read_en, RES_write_en, hRES_read_address,
          wout_read_address, sigm_read_address, RES_write_address, RES_write_data_in};
    total++;
    if (ov !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", ov);
    end
    reset = 1'b0;
    Start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (wout_read_en !== 1'b0 || Done !== 1'b0) begin
      bad++;
      $display("FAIL reset_wins_over_start wout_en=%b done=%b want 0 0", wout_read_en, Done);
    end
  endtask

  task automatic test_unit_weights();
    int span, w0, d0, o0;
    logic fe;
    logic [1:0] fa;
    load_unit();
    w0 = wr_total; d0 = done_total; o0 = order_bad;
    run_pass(span, fe, fa);
    total++;
    if (span !== 390) begin
      bad++;
      $display("FAIL unit_latency got=%0d want=390", span);
    end
    total++;
    if (fe !== 1'b1 || fa !== 2'd0) begin
      bad++;
      $display("FAIL first_wout en=%b addr=%0d want en=1 addr=0", fe, fa);
    end
    @(negedge clk);
    total++;
    if (Done !== 1'b0) begin
      bad++;
      $display("FAIL done_one_cycle got=%b want=0", Done);
    end
    total++;
    if (wr_total - w0 !== 64 || done_total - d0 !== 1) begin
      bad++;
      $display("FAIL unit_counts writes=%0d dones=%0d want 64 1", wr_total - w0, done_total - d0);
    end
    total++;
    if (order_bad != o0) begin
      bad++;
      $display("FAIL unit_write_order errors=%0d want=0", order_bad - o0);
    end
    for (int r = 0; r < 64; r++) begin
      total++;
      if (res_mem[r] !== 8'd1) begin
        bad++;
        $display("FAIL unit_row%0d got=%0d want=1", r, res_mem[r]);
      end
    end
  endtask

  task automatic test_ramp();
    int span, w0, o0;
    logic fe;
    logic [1:0] fa;
    logic [7:0] expv;
    load_ramp();
    w0 = wr_total; o0 = order_bad;
    run_pass(span, fe, fa);
    @(negedge clk);
    total++;
    if (span !== 390 || wr_total - w0 !== 64) begin
      bad++;
      $display("FAIL ramp_pass span=%0d writes=%0d want 390 64", span, wr_total - w0);
    end
    total++;
    if (order_bad != o0) begin
      bad++;
      $display("FAIL ramp_write_order errors=%0d want=0", order_bad - o0);
    end
    for (int r = 0; r < 64; r++) begin
      expv = 8'((2560 + 20 * r) >> 8);
      total++;
      if (res_mem[r] !== expv) begin
        bad++;
        $display("FAIL ramp_row%0d got=%0d want=%0d", r, res_mem[r], expv);
      end
    end
    total++;
    if (res_mem[63] !== 8'd14) begin
      bad++;
      $display("FAIL ramp_last_row got=%0d want=14", res_mem[63]);
    end
  endtask

  task automatic test_overflow();
    int span, w0;
    logic fe;
    logic [1:0] fa;
    logic [7:0] expv;
`ifdef OUT_LAYER_SATURATE_EN
    expv = 8'd255;
`else
    expv = 8'd251;
`endif
    for (int i = 0; i < 128; i++) hmem[i] = 8'd255;
    wmem[0] = 8'd255; wmem[1] = 8'd255; wmem[2] = 8'd255;
    w0 = wr_total;
    run_pass(span, fe, fa);
    @(negedge clk);
    total++;
    if (span !== 390 || wr_total - w0 !== 64) begin
      bad++;
      $display("FAIL overflow_pass span=%0d writes=%0d want 390 64", span, wr_total - w0);
    end
    for (int r = 0; r < 64; r++) begin
      total++;
      if (res_mem[r] !== expv) begin
        bad++;
        $display("FAIL overflow_row%0d got=%0d want=%0d", r, res_mem[r], expv);
      end
    end
  endtask

  task automatic test_reset_mid_pass();
    int w0, d0, wr_at, span;
    logic fe;
    logic [1:0] fa;
    logic [35:0] ov;
    logic [7:0] expv;
    load_ramp();
    w0 = wr_total; d0 = done_total;
    @(negedge clk);
    Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    wr_at = wr_total - w0;
    total++;
    if (wr_at !== 16) begin
      bad++;
      $display("FAIL mid_reset_rows_written got=%0d want=16", wr_at);
    end
    @(negedge clk);
    ov = {Done, hRES_read_en, wout_read_en, sigm_read_en, RES_write_en, hRES_read_address,
          wout_read_address, sigm_read_address, RES_write_address, RES_write_data_in};
    total++;
    if (ov !== '0) begin
      bad++;
      $display("FAIL mid_reset_outputs got=%h want=0", ov);
    end
    repeat (450) @(negedge clk);
    #1;
    total++;
    if (wr_total - w0 !== wr_at || done_total !== d0) begin
      bad++;
      $display("FAIL mid_reset_quiet writes=%0d dones=%0d want %0d 0", wr_total - w0, done_total - d0, wr_at);
    end
    for (int r = 0; r < 16; r++) begin
      expv = 8'((2560 + 20 * r) >> 8);
      total++;
      if (res_mem[r] !== expv) begin
        bad++;
        $display("FAIL mid_reset_kept_row%0d got=%0d want=%0d", r, res_mem[r], expv);
      end
    end
    load_unit();
    w0 = wr_total; d0 = done_total;
    run_pass(span, fe, fa);
    @(negedge clk);
    total++;
    if (span !== 390 || wr_total - w0 !== 64 || done_total - d0 !== 1) begin
      bad++;
      $display("FAIL post_reset_pass span=%0d writes=%0d dones=%0d want 390 64 1",
               span, wr_total - w0, done_total - d0);
    end
    for (int r = 0; r < 64; r++) begin
      total++;
      if (res_mem[r] !== 8'd1) begin
        bad++;
        $display("FAIL post_reset_row%0d got=%0d want=1", r, res_mem[r]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, n, w0, d0, o0;
    int done_at [2];
    logic [7:0] expv;
    load_ramp();
    done_at[0] = -1;
    done_at[1] = -1;
    n = 0;
    w0 = wr_total; d0 = done_total; o0 = order_bad;
    @(negedge clk);
    Start = 1'b1;
    cyc = 0;
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      cyc++;
      if (Done === 1'b1) begin
        done_at[n] = cyc;
        n++;
        if (n == 2) break;
      end
    end
    Start = 1'b0;
    total++;
    if (done_at[0] !== 389 || done_at[1] !== 779) begin
      bad++;
      $display("FAIL held_start_done_cycles got=%0d,%0d want=389,779", done_at[0], done_at[1]);
    end
    repeat (5) @(negedge clk);
    #1;
    total++;
    if (wr_total - w0 !== 128 || done_total - d0 !== 2) begin
      bad++;
      $display("FAIL held_start_counts writes=%0d dones=%0d want 128 2", wr_total - w0, done_total - d0);
    end
    total++;
    if (wout_read_en !== 1'b0 || hRES_read_en !== 1'b0) begin
      bad++;
      $display("FAIL held_start_idle wout_en=%b hres_en=%b want 0 0", wout_read_en, hRES_read_en);
    end
    total++;
    if (order_bad != o0) begin
      bad++;
      $display("FAIL held_start_order errors=%0d want=0", order_bad - o0);
    end
    for (int r = 0; r < 64; r += 9) begin
      expv = 8'((2560 + 20 * r) >> 8);
      total++;
      if (res_mem[r] !== expv) begin
        bad++;
        $display("FAIL held_start_row%0d got=%0d want=%0d", r, res_mem[r], expv);
      end
    end
  endtask

  task automatic test_read_enables_exclusive();
    total++;
    if (overlap !== 0) begin
      bad++;
      $display("FAIL enable_overlap cycles=%0d want=0", overlap);
    end
  endtask

  initial begin
    reset = 1'b1;
    Start = 1'b0;
    for (int i = 0; i < 256; i++) smem[i] = 8'(i);
    for (int i = 0; i < 128; i++) hmem[i] = '0;
    for (int i = 0; i < 4; i++) wmem[i] = '0;
    test_reset();
    test_unit_weights();
    test_ramp();
    test_overflow();
    test_reset_mid_pass();
    test_back_to_back();
    test_read_enables_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/out_layer.md
# out_layer

Output-layer stage of the MLP coprocessor. It runs after the hidden layer has filled hRES_RAM, which holds 64 rows × 2 hidden activations, interleaved. For each row it computes bias + h1·w1 + h2·w2 using the 3-entry wout_RAM, maps the result through the sigmoid LUT in sigm_RAM, and writes one 8-bit result per row into RES_RAM. The AXI-Stream wrapper then drains RES_RAM.

## Interface
Parameters:
- width, 8, bits per RAM word
- hRES_depth_bits, 7, hRES_RAM address width (128 words)
- wout_depth_bits, 2, wout_RAM address width (entries 0..2 used)
- sigm_depth_bits, 8, sigm_RAM address width
- RES_depth_bits, 6, RES_RAM address width (64 words)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- Start  in  1  begin one full 64-row pass; sampled in IDLE only
- Done  out  1  one-cycle pulse after the final RES write
- hRES_read_en  out  1  hRES_RAM read enable
- hRES_read_address  out  hRES_depth_bits  row r: 2r = neuron 1, 2r+1 = neuron 2
- hRES_read_data_out  in  width  valid one cycle after address
- wout_read_en  out  1  wout_RAM read enable
- wout_read_address  out  wout_depth_bits  0 = bias, 1 = w1, 2 = w2
- wout_read_data_out  in  width  valid one cycle after address
- sigm_read_en  out  1  sigm_RAM read enable
- sigm_read_address  out  sigm_depth_bits  LUT index
- sigm_read_data_out  in  width  valid one cycle after address
- RES_write_en  out  1  RES_RAM write strobe
- RES_write_address  out  RES_depth_bits  row index r
- RES_write_data_in  out  width  sigmoid output for row r

## Operation
- States: IDLE, LOAD_W, READ_H1, READ_H2, CAP_H2, ACCUM, SIG_LOOKUP, WRITE, FINISH.
- IDLE: outputs held at reset values. If Start=1, go to LOAD_W; the row counter resets to 0.
- LOAD_W: present wout addresses 0, 1, 2 on consecutive cycles. Capture bias, w1, w2 one cycle later each. Takes 4 cycles, then READ_H1.
- READ_H1: present hRES address 2r.
- READ_H2: present 2r+1; capture h1.
- CAP_H2: capture h2.
- ACCUM: acc = {bias,8'b0} + h1·w1 + h2·w2. All unsigned; acc is 18 bits and cannot overflow (max 195330).
- SIG_LOOKUP: sigm_read_address = acc[15:8], i.e. (acc>>8) truncated to 8 bits. sigm_read_en=1.
- WRITE: RES_write_en=1, RES_write_address=r, RES_write_data_in=sigm_read_data_out.
  - If r=63, go to FINISH.
  - Otherwise r increments and the FSM goes to READ_H1.
- FINISH: Done=1 for exactly one cycle, then IDLE.
- Weights are loaded once per pass. The weights are not re-read per row.
- Start asserted while not in IDLE is ignored; it is not queued.
- hRES and RES addresses never wrap within a pass. The row counter stops at 63.

## Timing
- Reset values: Done=0, every *_read_en=0, every address=0, RES_write_en=0, RES_write_data_in=0.
- All RAMs are synchronous-read with 1-cycle latency. Each read enable is high only in the cycle its address is presented.
- Start sampled at cycle 0 → first wout address at cycle 1.
- Per row: 6 cycles, READ_H1 through WRITE.
- RES_write_en is high exactly one cycle per row, 64 pulses total per pass.
- Full pass latency: 1 + 4 + 64·6 + 1 = 390 cycles from the Start-sampling edge to Done.
- Done rises the cycle after the 64th write. Back-to-back Start is accepted the cycle after Done.
- Reset mid-pass:
  - the next edge forces IDLE and all reset values;
  - no Done pulse and no further writes;
  - rows already written remain in RES_RAM.
- Reset and Start in the same cycle: reset wins.

## Configuration
- OUT_LAYER_SATURATE_EN controls how the LUT index is derived.
- Defined: index = (acc>>8) clamped to 255. Large sums select the top LUT entry.
- Undefined (default): index = acc[15:8]; higher bits are discarded. This matches the hidden layer's truncation behaviour.
- Both builds have identical cycle timing.

## Test plan
- Setup for all scenarios: sigm_RAM loaded with identity (sigm[i]=i).
- bias=0, w1=w2=1, all h=128, Start → 64 writes of 1 (acc=256); Done at cycle 390.
- bias=10, w1=2, w2=3, row r h1=h2=r·4 → RES[r] = 10 + (20r>>8). Row 63 → 14. Write order r=0..63.
- bias=255, w1=w2=255, all h=255 → 251 without OUT_LAYER_SATURATE_EN (763 mod 256); 255 with it.
- Reset pulsed at cycle 100 mid-pass → no Done; no RES_write_en after reset; next Start gives a full correct pass.
- Start held high continuously → one Done per 390 cycles. Start pulses during a pass are ignored; read enables never overlap.
